// File: rtl/playback_prefetch_fifo_if.sv
// rtl/playback_prefetch_fifo_if.sv - RAM wrapper read handshake between prefetch FIFO and sample RAM
interface playback_prefetch_fifo_if #(
    parameter int DW = 16,
    parameter int AW = 26
);
    logic          rdy;
    logic [AW-1:0] address;
    logic          read_request;
    logic          rd_data_pres;
    logic          read_ack;
    logic [DW-1:0] data_out;

    modport master (
        input  rdy,
        output address,
        output read_request,
        input  rd_data_pres,
        output read_ack,
        input  data_out
    );

    modport slave (
        output rdy,
        input  address,
        input  read_request,
        output rd_data_pres,
        input  read_ack,
        output data_out
    );
endinterface

// File: rtl/playback_prefetch_fifo.sv
// rtl/playback_prefetch_fifo.sv - prefetches audio samples from RAM into a small FIFO drained by the codec
module playback_prefetch_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 16,
    parameter int AW    = 26
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [AW-1:0]            max_ram_address,
    playback_prefetch_fifo_if.master ram,
    input  logic                     s_req,
    output logic [DW-1:0]            audio_out,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     underrun,
    output logic                     done
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          s_req_q;
    logic          pop_evt, pop_hit, push;

    assign pop_evt = enable & s_req & ~s_req_q;
    assign pop_hit = pop_evt & (fill_level != '0);
    // push can only happen while REQ is live, so an aborted request never writes
    assign push    = enable & (state == REQ) & ram.rd_data_pres;

    assign ram.read_request = (state == REQ);
    assign ram.read_ack     = (state == ACK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (ram.rdy && !done && fill_level < FULL) state_nxt = REQ;
                REQ:  if (ram.rd_data_pres) state_nxt = ACK;
                ACK:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_req_q <= 1'b0;
        end else begin
            s_req_q <= s_req;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ram.data_out;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill_level  <= '0;
            audio_out   <= '0;
            underrun    <= 1'b0;
            done        <= 1'b0;
            ram.address <= '0;
        end else if (!enable) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill_level  <= '0;
            audio_out   <= '0;
            underrun    <= 1'b0;
            done        <= 1'b0;
            ram.address <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // an empty pop outputs silence; a same-edge push is not bypassed
            if (pop_evt) begin
                if (fill_level != '0) begin
                    audio_out <= mem[rd_ptr];
                    rd_ptr    <= rd_ptr + 1'b1;
                end else begin
                    audio_out <= '0;
                    underrun  <= 1'b1;
                end
            end
            case ({push, pop_hit})
                2'b10:   fill_level <= fill_level + 1'b1;
                2'b01:   fill_level <= fill_level - 1'b1;
                default: fill_level <= fill_level;
            endcase
            if (state == ACK) begin
                if (ram.address == max_ram_address) begin
                    done <= 1'b1;
                end else begin
                    ram.address <= ram.address + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_playback_prefetch_fifo.sv
// tb/tb_playback_prefetch_fifo.sv - scoreboard bench for the playback prefetch FIFO
module tb_playback_prefetch_fifo;
    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        rdy;
    logic        s_req;
    logic [25:0] max_ram_address;
    logic [15:0] audio_out;
    logic [3:0]  fill_level;
    logic        underrun;
    logic        done;

    logic        ram_auto  = 1'b0;
    logic        ram_pres  = 1'b0;
    logic [15:0] ram_data  = '0;
    logic        rd_force  = 1'b0;
    logic [15:0] force_data = '0;
    int          ram_cnt   = 0;

    logic        req_prev  = 1'b0;
    logic [25:0] req_addrs [$];
    logic [15:0] sb [$];

    int vec_cnt = 0;
    int err_cnt = 0;

    playback_prefetch_fifo_if #(.DW(16), .AW(26)) bus ();

    assign bus.rdy          = rdy;
    assign bus.rd_data_pres = ram_pres | rd_force;
    assign bus.data_out     = rd_force ? force_data : ram_data;

    playback_prefetch_fifo #(.DEPTH(8), .DW(16), .AW(26)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .max_ram_address (max_ram_address),
        .ram             (bus),
        .s_req           (s_req),
        .audio_out       (audio_out),
        .fill_level      (fill_level),
        .underrun        (underrun),
        .done            (done)
    );

    always #5 clk = ~clk;

    // RAM model: data valid two cycles after the request is seen, data = address
    always @(negedge clk) begin
        if (ram_auto && bus.read_request) begin
            ram_cnt = ram_cnt + 1;
            if (ram_cnt == 2) begin
                ram_pres = 1'b1;
                ram_data = bus.address[15:0];
            end else begin
                ram_pres = 1'b0;
            end
        end else begin
            ram_cnt  = 0;
            ram_pres = 1'b0;
        end
        if (bus.read_request && !req_prev) req_addrs.push_back(bus.address);
        req_prev = bus.read_request;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_pop(input logic [15:0] exp);
        @(negedge clk);
        s_req = 1'b1;
        sb.push_back(exp);
        @(posedge clk);
        #1 chk("audio_out", {16'h0, audio_out}, {16'h0, sb.pop_front()});
        @(negedge clk);
        s_req = 1'b0;
    endtask

    task automatic wait_fill(input logic [3:0] lvl);
        for (int i = 0; i < 300; i++) begin
            if (fill_level == lvl) break;
            @(negedge clk);
        end
        chk("fill_reach", fill_level, lvl);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 50; i++) begin
            if (bus.read_request) break;
            @(negedge clk);
        end
        chk("req_seen", bus.read_request, 1);
    endtask

    task automatic flush();
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; rdy = 1'b0; s_req = 1'b0;
        max_ram_address = 26'd1000;
        repeat (3) @(negedge clk);
        chk("rst_req",   bus.read_request, 0);
        chk("rst_ack",   bus.read_ack, 0);
        chk("rst_addr",  bus.address, 0);
        chk("rst_fill",  fill_level, 0);
        chk("rst_audio", audio_out, 0);
        chk("rst_under", underrun, 0);
        chk("rst_done",  done, 0);

        // fill
        reset = 1'b1; enable = 1'b1; rdy = 1'b1; ram_auto = 1'b1;
        wait_fill(4'd8);
        repeat (10) @(negedge clk);
        chk("fill_req_low", bus.read_request, 0);
        chk("fill_nreq", req_addrs.size(), 8);
        for (int i = 0; i < 8 && i < req_addrs.size(); i++) chk("fill_addr", req_addrs[i], i);
        chk("fill_next_addr", bus.address, 8);

        // drain three with refill held off, then refill
        rdy = 1'b0;
        do_pop(16'd0); do_pop(16'd1); do_pop(16'd2);
        chk("drain_fill5", fill_level, 5);
        req_addrs.delete();
        rdy = 1'b1;
        wait_fill(4'd8);
        repeat (10) @(negedge clk);
        chk("refill_nreq", req_addrs.size(), 3);
        for (int i = 0; i < 3 && i < req_addrs.size(); i++) chk("refill_addr", req_addrs[i], 8 + i);

        // drain to empty, then underrun
        rdy = 1'b0;
        for (int i = 3; i <= 10; i++) do_pop(16'(i));
        chk("empty_fill", fill_level, 0);
        chk("pre_under", underrun, 0);
        do_pop(16'd0);
        chk("underrun_set", underrun, 1);
        repeat (5) @(negedge clk);
        chk("underrun_sticky", underrun, 1);
        flush();
        chk("flush_under", underrun, 0);
        chk("flush_fill",  fill_level, 0);
        chk("flush_addr",  bus.address, 0);
        chk("flush_audio", audio_out, 0);

        // end of data
        req_addrs.delete();
        max_ram_address = 26'd3;
        enable = 1'b1; rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (done) break;
            @(negedge clk);
        end
        chk("eod_done", done, 1);
        repeat (10) @(negedge clk);
        chk("eod_addr", bus.address, 3);
        chk("eod_fill", fill_level, 4);
        chk("eod_nreq", req_addrs.size(), 4);
        for (int i = 0; i < 4 && i < req_addrs.size(); i++) chk("eod_req_addr", req_addrs[i], i);
        for (int i = 0; i < 4; i++) do_pop(16'(i));
        repeat (5) @(negedge clk);
        chk("eod_drained", fill_level, 0);
        chk("eod_done_hold", done, 1);
        chk("eod_no_more", req_addrs.size(), 4);

        // simultaneous push of 5 and pop at fill 2
        flush();
        max_ram_address = 26'd1000;
        enable = 1'b1; rdy = 1'b1;
        wait_fill(4'd2);
        rdy = 1'b0;
        repeat (5) @(negedge clk);
        chk("sim_fill_pre", fill_level, 2);
        ram_auto = 1'b0;
        rdy = 1'b1;
        @(negedge clk);
        wait_req();
        rdy = 1'b0;
        rd_force = 1'b1; force_data = 16'd5; s_req = 1'b1;
        sb.push_back(16'd0);
        @(posedge clk);
        #1 chk("sim_audio", {16'h0, audio_out}, {16'h0, sb.pop_front()});
        chk("sim_fill", fill_level, 2);
        chk("sim_ack", bus.read_ack, 1);
        @(negedge clk);
        rd_force = 1'b0; s_req = 1'b0;
        do_pop(16'd1);
        do_pop(16'd5);
        chk("sim_empty", fill_level, 0);

        // abort an outstanding request
        flush();
        enable = 1'b1; rdy = 1'b1;
        @(negedge clk);
        wait_req();
        chk("abort_addr_pre", bus.address, 0);
        enable = 1'b0;
        @(posedge clk);
        #1 chk("abort_req_drop", bus.read_request, 0);
        @(negedge clk);
        rd_force = 1'b1; force_data = 16'h77;
        @(posedge clk);
        #1 chk("abort_no_ack", bus.read_ack, 0);
        @(negedge clk);
        rd_force = 1'b0;
        @(posedge clk);
        #1 chk("abort_no_ack2", bus.read_ack, 0);
        chk("abort_fill", fill_level, 0);
        chk("abort_addr", bus.address, 0);

        // reset while a request is outstanding
        @(negedge clk);
        enable = 1'b1; rdy = 1'b1;
        @(negedge clk);
        wait_req();
        rd_force = 1'b1; force_data = 16'h55;
        reset = 1'b0;
        #1 chk("rst_mid_req", bus.read_request, 0);
        @(posedge clk);
        #1 chk("rst_mid_fill", fill_level, 0);
        chk("rst_mid_ack", bus.read_ack, 0);
        @(negedge clk);
        rd_force = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 chk("first_req_after_rst", bus.read_request, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/playback_prefetch_fifo.md
PLAYBACK_PREFETCH_FIFO -- requirements
Module: playback_prefetch_fifo

Interface
REQ-001 Parameters SHALL be: DEPTH, 8, FIFO entries (power of 2); DW, 16, sample width; AW, 26, RAM address width.
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  single system clock (RAM wrapper user clock domain)
  reset  in  1  asynchronous, active-low reset
  enable  in  1  playback mode; low = synchronous flush
  rdy  in  1  RAM wrapper ready; no new request issued while low
  max_ram_address  in  AW  last valid sample address
  address  out  AW  RAM read address, stable while read_request high
  read_request  out  1  RAM read request
  rd_data_pres  in  1  RAM read data valid
  read_ack  out  1  one-cycle acknowledge of consumed read data
  data_out  in  DW  RAM read data
  s_req  in  1  codec sample request strobe (level, one sample per rising edge)
  audio_out  out  DW  sample presented to codec
  fill_level  out  4  current FIFO occupancy, 0..DEPTH
  underrun  out  1  sticky: s_req edge seen with FIFO empty
  done  out  1  sticky: sample at max_ram_address fetched

Function
REQ-003 Read FSM SHALL have states IDLE, REQ, ACK.
REQ-004 IDLE->REQ when enable & rdy & !done & fill_level<DEPTH; read_request SHALL go high on that edge with address unchanged.
REQ-005 In REQ, read_request SHALL stay high and address stable until rd_data_pres=1.
REQ-006 REQ->ACK on rd_data_pres=1: data_out written to FIFO tail, read_request low, read_ack high, all on the same edge.
REQ-007 ACK SHALL last exactly one cycle: read_ack low on exit; address<=address+1, or done<=1 with address held if address==max_ram_address; ->IDLE.
REQ-008 At most one read outstanding; issued reads SHALL never exceed free FIFO space (push in REQ guaranteed to fit).
REQ-009 s_req SHALL be registered once; pop event = s_req & !s_req_q (rising edge, one per edge).
REQ-010 Pop with fill_level>0: audio_out<=head sample, head advances, fill_level-1, all on same edge.
REQ-011 Pop with fill_level=0: audio_out<=0, underrun<=1, pointers unchanged.
REQ-012 Push and pop in same cycle SHALL both occur; fill_level unchanged; with fill_level=0, popped value SHALL be 0 (no bypass) and underrun set.
REQ-013 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; fill_level SHALL be tracked separately to distinguish full/empty.
REQ-014 enable low SHALL on next edge: FIFO empty, address=0, FSM IDLE, read_request=0, read_ack=0, done=0, underrun=0, audio_out=0; pops ignored.
REQ-015 enable dropping while in REQ SHALL abort the request; any later rd_data_pres SHALL be ignored and not acknowledged.
REQ-016 rdy low SHALL only block IDLE->REQ; REQ and ACK SHALL complete regardless.
REQ-017 done=1 SHALL stop new requests; FIFO SHALL continue draining via s_req.

Reset
REQ-018 reset low SHALL asynchronously force: FSM IDLE, address=0, read_request=0, read_ack=0, audio_out=0, fill_level=0, pointers=0, underrun=0, done=0, s_req_q=0.
REQ-019 Reset asserted mid-REQ SHALL drop read_request immediately; no FIFO write occurs.
REQ-020 First request after reset release SHALL require one clean edge with enable=1, rdy=1.

Verification
REQ-021 Fill: enable=1, rdy=1, RAM model answers rd_data_pres 2 cycles after request with data=address -> 8 requests at addresses 0..7, fill_level=8, read_request held low thereafter.
REQ-022 Drain: from full, 3 s_req rising edges -> audio_out 0,1,2 in order, fill_level 5 then refills to 8 via addresses 8,9,10.
REQ-023 Underrun: fill_level=0, s_req edge -> audio_out=0, underrun=1, stays 1 until enable low.
REQ-024 End of data: max_ram_address=3 -> reads 0..3 only, done=1 after ack of address 3, address holds 3, FIFO drains 0..3.
REQ-025 Simultaneous: push of sample 5 on same edge as pop with fill_level=2 -> audio_out=head, fill_level stays 2.
REQ-026 Abort: enable low during REQ, then late rd_data_pres -> no read_ack, fill_level=0, address=0.
